mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between two pipeline stages.
- The instruction-fetch stage (IF, 32-bit reads) and the data-memory stage (DM, 64-bit ld/sd) both request through this block.
- It sequences each access through an IDLE/ACCESS/DONE state machine and generates per-requester stall signals that feed the pipeline hazard/stall logic.
- It sits between the pipelined CPU core and the shared memory model.

Parameters:
- ADDR_W, 32: byte-address width.
- LATENCY, 2: memory read/write latency in cycles. Legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  IF access request; held high until if_done.
- if_addr  in  ADDR_W  IF byte address, 4-byte aligned.
- if_rdata  out  32  fetched instruction.
- if_done  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  stall request to IF.
- dm_req  in  1  DM access request; held high until dm_done.
- dm_we  in  1  1 = sd (write), 0 = ld (read).
- dm_addr  in  ADDR_W  DM byte address, 8-byte aligned.
- dm_wdata  in  64  store data.
- dm_rdata  out  64  load data.
- dm_done  out  1  one-cycle completion pulse for DM.
- dm_stall  out  1  stall request to DM.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  doubleword address, bits [2:0] forced to 0.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data.
- busy  out  1  high when state is not IDLE.
- owner  out  1  current grant: 0 = IF, 1 = DM.

Behaviour:
- Reset: state IDLE, counter 0, and every output 0, including both rdata registers and last-owner. Reset asserted mid-access aborts it: mem_en=0 in the next cycle, no done pulse.
- IDLE, arbitration:
  - dm_req alone, or both requests → grant DM.
  - if_req alone → grant IF.
  - Neither → stay in IDLE.
  - On grant, latch addr, we and wdata (dm_we is forced to 0 for an IF grant), set owner, go to ACCESS with cnt=1.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata are driven from the latched values and held stable.
  - cnt increments each cycle.
  - In the cycle with cnt==LATENCY, mem_rdata is captured at the clock edge and the state goes to DONE:
    - owner DM → dm_rdata = mem_rdata (captured on reads only; writes leave it unchanged).
    - owner IF → if_rdata = mem_rdata[63:32] if latched addr[2]=1, else mem_rdata[31:0].
- DONE:
  - Exactly one cycle; mem_en=0.
  - done pulse for the owner; then IDLE. No arbitration in DONE.
- Timing:
  - Grant in cycle 0 → done in cycle LATENCY+1 → next grant no earlier than cycle LATENCY+2.
  - Throughput is one access per LATENCY+2 cycles.
- Stall: if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done. Both are combinational from registered done.
- rdata registers hold their value until the next capture for the same requester.
- Requester drops req mid-access: the access still completes and done still pulses (it may be ignored); no retry.
- Latched address/data make input changes during ACCESS irrelevant.
- Counter width: 4 bits. Wrap is impossible because the counter resets on grant.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined: a last-owner register is updated at each grant. If both requests are present in IDLE and last-owner is DM, grant IF. This gives strict alternation under contention.
- Undefined: fixed priority, DM always wins. IF is starved while dm_req is continuously high.

Decomposition:
- Package mem_arb_pkg:
  - state enum ST_IDLE/ST_ACCESS/ST_DONE.
  - owner constants OWN_IF=0, OWN_DM=1.
  - XLEN=64, ILEN=32.
- Sub-module mem_arb_lat_counter: load-to-1 on grant, increment during ACCESS, terminal-count output when cnt==LATENCY.

Test Plan (LATENCY=2):
- IF read: if_req=1, if_addr=0x4, mem_rdata=0x11112222_33334444 → mem_en cycles 1-2 with mem_addr=0x0; if_done=1 and if_rdata=0x11112222 in cycle 3; if_stall=1 in cycles 0-2, 0 in cycle 3.
- Both requesters assert in cycle 0 (DM read at 0x10, IF read at 0x0):
  - DM is granted first, dm_done in cycle 3.
  - IF is granted in cycle 4, if_done in cycle 7.
  - if_stall stays high in cycles 0-6.
- DM write: dm_we=1, addr 0x18, wdata 0xDEADBEEF_CAFEF00D → mem_en=mem_we=1 with that addr/data in cycles 1-2; dm_done in cycle 3; dm_rdata unchanged.
- Continuous contention for 12 cycles:
  - Undefined macro → three DM accesses, zero IF accesses.
  - ARB_FAIR_EN defined → order DM, IF, DM.
- Reset pulse in cycle 1 of a DM access → mem_en=0 and busy=0 from cycle 2; dm_done never pulses; a new request is granted normally afterwards.
- dm_req dropped in cycle 1 → mem_en is still held through cycle 2; dm_done pulses in cycle 3; no second access is issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, owner codes and word widths
// for the unified-memory port arbiter (IF fetch vs. DM ld/sd).
package mem_arb_pkg;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int CNT_W = 4;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Select the 32-bit instruction word out of a fetched doubleword.
    function automatic logic [ILEN-1:0] pick_word(
        input logic [XLEN-1:0] dw,
        input logic            hi
    );
        return hi ? dw[XLEN-1:ILEN] : dw[ILEN-1:0];
    endfunction

endpackage

// File: rtl/mem_arb_lat_counter.sv
// mem_arb_lat_counter: access latency counter for the memory arbiter.
// Ports: clk, reset (sync, active-high), load_i (grant: cnt<=1),
//   inc_i (ACCESS: cnt++), tc_o (high while in ACCESS with cnt==LATENCY).
module mem_arb_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = inc_i && (cnt_q == LAT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between IF (32b
// fetch) and DM (64b ld/sd) via an IDLE/ACCESS/DONE sequencer.
// Ports: clk, reset (sync, active-high); if_req/if_addr -> if_rdata,
//   if_done, if_stall; dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata, dm_done,
//   dm_stall; mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata; busy, owner.
// Build option: define ARB_FAIR_EN for alternating grants under contention;
//   otherwise DM has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [ILEN-1:0]   if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic [XLEN-1:0]   dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy,
    output logic              owner
);

    state_e state_q, state_d;

    logic grant;
    logic grant_dm;
    logic both_pick_if;
    logic in_access;
    logic tc;

    // Bit 2 is kept: it selects the instruction half of a doubleword.
    logic [ADDR_W-1:2] addr_q, addr_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic [ILEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;

    // Requesters guarantee alignment; the low bits carry no information.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

`ifdef ARB_FAIR_EN
    logic last_q, last_d;

    assign last_d       = grant ? grant_dm : last_q;
    assign both_pick_if = (last_q == OWN_DM);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign both_pick_if = 1'b0;
`endif

    assign in_access = (state_q == ST_ACCESS);
    assign grant     = (state_q == ST_IDLE) && (if_req || dm_req);
    assign grant_dm  = dm_req && !(if_req && both_pick_if);

    mem_arb_lat_counter #(
        .LATENCY (LATENCY)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (grant),
        .inc_i  (in_access),
        .tc_o   (tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (grant) state_d = ST_ACCESS;
            ST_ACCESS: if (tc) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;

        if (grant) begin
            owner_d = grant_dm ? OWN_DM : OWN_IF;
            addr_d  = grant_dm ? dm_addr[ADDR_W-1:2]
                               : if_addr[ADDR_W-1:2];
            we_d    = grant_dm & dm_we;
            wdata_d = dm_wdata;
        end

        // Read data is valid at the edge that closes the last ACCESS cycle.
        if (in_access && tc) begin
            if (owner_q == OWN_DM) begin
                dm_done_d = 1'b1;
                if (!we_q) begin
                    dm_rdata_d = mem_rdata;
                end
            end else begin
                if_done_d  = 1'b1;
                if_rdata_d = pick_word(mem_rdata, addr_q[2]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            owner_q    <= OWN_IF;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
        end
    end

    assign mem_en    = in_access;
    assign mem_we    = in_access & we_q;
    assign mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wdata = wdata_q;

    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-schedule model of the arbiter.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done, if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic [63:0] dm_rdata;
    logic        dm_done, dm_stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        busy, owner;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [63:0] env_mem[logic [31:0]];
    logic [63:0] ref_mem[logic [31:0]];

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0F0F, a * 32'h0001_0003 + 32'h1357_9BDF};
    endfunction

    function automatic logic [63:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : pat(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [63:0] d);
        env_mem[a] = d;
        ref_mem[a] = d;
    endtask

    always @(posedge clk) begin
        if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
        #1;
        mem_rdata = env_rd(mem_addr);
    end

    // ---------------- reference model ----------------
    // Schedule view: an access granted in cycle g occupies the port in
    // g+1..g+LAT, reports done in g+LAT+1; the arbiter is free from g+LAT+2.
    int          cyc = 0;
    bit          act = 1'b0;
    int          g = 0;
    bit          own_dm = 1'b0;
    logic [31:0] l_addr = '0;
    bit          l_we = 1'b0;
    logic [63:0] l_wd = '0;
    bit          last_dm = 1'b0;
    logic [31:0] e_ifr = '0;
    logic [63:0] e_dmr = '0;

    always @(negedge clk) begin
        int k;
        bit e_en, e_busy, e_done, e_ifd, e_dmd;
        logic [31:0] dw;
        logic [63:0] rd;
        bit pick_dm;
        k      = act ? cyc - g : -1;
        e_en   = act && k >= 1 && k <= LAT;
        e_busy = act && k >= 1 && k <= LAT + 1;
        e_done = act && k == LAT + 1;
        e_ifd  = e_done && !own_dm;
        e_dmd  = e_done && own_dm;
        dw     = {l_addr[31:3], 3'b000};

        if (chk_en) begin
            chk("busy", 64'(busy), 64'(e_busy));
            chk("mem_en", 64'(mem_en), 64'(e_en));
            chk("if_done", 64'(if_done), 64'(e_ifd));
            chk("dm_done", 64'(dm_done), 64'(e_dmd));
            chk("if_stall", 64'(if_stall), 64'(if_req && !e_ifd));
            chk("dm_stall", 64'(dm_stall), 64'(dm_req && !e_dmd));
            chk("if_rdata", 64'(if_rdata), 64'(e_ifr));
            chk("dm_rdata", dm_rdata, e_dmr);
            if (e_busy) chk("owner", 64'(owner), 64'(own_dm));
            if (e_en) begin
                chk("mem_we", 64'(mem_we), 64'(l_we));
                chk("mem_addr", 64'(mem_addr), 64'(dw));
                if (l_we) chk("mem_wdata", mem_wdata, l_wd);
            end
        end

        if (e_en && l_we) ref_mem[dw] = l_wd;

        if (reset) begin
            act     = 1'b0;
            e_ifr   = '0;
            e_dmr   = '0;
            last_dm = 1'b0;
        end else begin
            if (act && k == LAT) begin
                rd = ref_rd(dw);
                if (own_dm && !l_we) e_dmr = rd;
                if (!own_dm) e_ifr = l_addr[2] ? rd[63:32] : rd[31:0];
            end
            if ((!act || k >= LAT + 2) && (if_req || dm_req)) begin
                pick_dm = dm_req && !(if_req && FAIR && last_dm);
                act     = 1'b1;
                g       = cyc;
                own_dm  = pick_dm;
                l_addr  = pick_dm ? dm_addr : if_addr;
                l_we    = pick_dm && dm_we;
                l_wd    = dm_wdata;
                last_dm = pick_dm;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    bit cont_log[$];
    int if_wait = 0;
    int dm_wait = 0;

    initial begin
        // Reset state
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_mem_en", 64'(mem_en), 64'd0);
                chk("rst_owner", 64'(owner), 64'd0);
                chk("rst_if_rdata", 64'(if_rdata), 64'd0);
                chk("rst_dm_rdata", dm_rdata, 64'd0);
                chk("rst_dones", 64'({if_done, dm_done}), 64'd0);
            end
        end
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // IF read of the upper word
        preload(32'h0, 64'h11112222_33334444);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h4; end
            if (c == 4) if_req = 1'b0;
            @(negedge clk);
            chk("t1_mem_en", 64'(mem_en), 64'(c == 1 || c == 2));
            if (c == 1 || c == 2) chk("t1_mem_addr", 64'(mem_addr), 64'h0);
            chk("t1_if_done", 64'(if_done), 64'(c == 3));
            chk("t1_if_stall", 64'(if_stall), 64'(c <= 2));
            if (c == 3) begin
                chk("t1_if_rdata", 64'(if_rdata), 64'h11112222);
                chk("t1_model_ifr", 64'(e_ifr), 64'h11112222);
            end
        end
        idle(2);

        // Simultaneous requests: DM first, then IF
        preload(32'h10, 64'h01234567_89ABCDEF);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            if (c == 0) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
                if_req = 1'b1; if_addr = 32'h0;
            end
            if (c == 4) dm_req = 1'b0;
            if (c == 8) if_req = 1'b0;
            @(negedge clk);
            chk("t2_dm_done", 64'(dm_done), 64'(c == 3));
            chk("t2_if_done", 64'(if_done), 64'(c == 7));
            chk("t2_if_stall", 64'(if_stall), 64'(c <= 6));
            if (c == 3) chk("t2_dm_rdata", dm_rdata, 64'h01234567_89ABCDEF);
            if (c == 7) chk("t2_if_rdata", 64'(if_rdata), 64'h33334444);
        end
        idle(2);

        // DM write leaves dm_rdata untouched
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (c == 0) begin
                dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h18;
                dm_wdata = 64'hDEADBEEF_CAFEF00D;
            end
            if (c == 4) begin dm_req = 1'b0; dm_we = 1'b0; end
            @(negedge clk);
            chk("t3_mem_en", 64'(mem_en), 64'(c == 1 || c == 2));
            if (c == 1 || c == 2) begin
                chk("t3_mem_we", 64'(mem_we), 64'd1);
                chk("t3_mem_addr", 64'(mem_addr), 64'h18);
                chk("t3_mem_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
            end
            chk("t3_dm_done", 64'(dm_done), 64'(c == 3));
            if (c == 3) chk("t3_dm_rdata", dm_rdata, 64'h01234567_89ABCDEF);
        end
        idle(2);

        // Reset during cycle 1 of a DM read aborts it
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            if (c == 0) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8; end
            if (c == 1) reset = 1'b1;
            if (c == 2) reset = 1'b0;
            if (c == 6) dm_req = 1'b0;
            @(negedge clk);
            if (c == 1) chk("t5_mem_en_c1", 64'(mem_en), 64'd1);
            if (c == 2) begin
                chk("t5_mem_en_c2", 64'(mem_en), 64'd0);
                chk("t5_busy_c2", 64'(busy), 64'd0);
                chk("t5_dm_rdata_clr", dm_rdata, 64'd0);
            end
            chk("t5_dm_done", 64'(dm_done), 64'(c == 5));
        end
        idle(2);

        // Requester drops dm_req after the grant
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            if (c == 0) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; end
            if (c == 1) dm_req = 1'b0;
            @(negedge clk);
            chk("t6_mem_en", 64'(mem_en), 64'(c == 1 || c == 2));
            chk("t6_dm_done", 64'(dm_done), 64'(c == 3));
            chk("t6_busy", 64'(busy), 64'(c >= 1 && c <= 3));
        end

        // Continuous contention from a fresh reset
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(1);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            if (c == 0) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h28;
                if_req = 1'b1; if_addr = 32'h30;
            end
            @(negedge clk);
            if (dm_done) cont_log.push_back(1'b1);
            if (if_done) cont_log.push_back(1'b0);
        end
        tick();
        dm_req = 1'b0;
        if_req = 1'b0;
        chk("t4_n_done", 64'(cont_log.size()), 64'd3);
        if (cont_log.size() == 3) begin
            chk("t4_first", 64'(cont_log[0]), 64'd1);
            chk("t4_second", 64'(cont_log[1]), FAIR ? 64'd0 : 64'd1);
            chk("t4_third", 64'(cont_log[2]), 64'd1);
        end
        idle(6);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit ifd_s, dmd_s;
            @(negedge clk);
            ifd_s = if_done;
            dmd_s = dm_done;
            if (if_req && !if_done) if_wait++; else if_wait = 0;
            if (dm_req && !dm_done) dm_wait++; else dm_wait = 0;
            if (if_wait > 100) begin
                chk("if_req_timeout", 64'(if_wait), 64'd100);
                if_wait = 0;
            end
            if (dm_wait > 100) begin
                chk("dm_req_timeout", 64'(dm_wait), 64'd100);
                dm_wait = 0;
            end
            tick();
            reset = ($urandom_range(0, 199) == 0);
            if (if_req && ifd_s) begin
                if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = ($urandom_range(0, 7) == 0) ? ($urandom & ~32'h3)
                                                      : 32'($urandom_range(0, 31)) << 2;
            end else if (if_req && $urandom_range(0, 49) == 0) begin
                if_req = 1'b0;
            end
            if (if_req && $urandom_range(0, 7) == 0) if_addr = $urandom & ~32'h3;
            if (dm_req && dmd_s) begin
                dm_req = 1'b0;
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1;
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = ($urandom_range(0, 7) == 0) ? ($urandom & ~32'h7)
                                                      : 32'($urandom_range(0, 15)) << 3;
                dm_wdata = {$urandom, $urandom};
            end else if (dm_req && $urandom_range(0, 49) == 0) begin
                dm_req = 1'b0;
            end
            if (dm_req && $urandom_range(0, 7) == 0) dm_wdata = {$urandom, $urandom};
        end
        tick();
        reset = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        idle(6);
        @(negedge clk);
        chk("final_idle", 64'(busy), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
